// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush controller for the 5-stage pipeline with stall watchdog and perf counter
module pipe_stall_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE   = 32'h0000_000e,
    parameter int          STALL_LIMIT = 16,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype,
    input  logic [31:0]      cp0_epc,
    input  logic             stall_cnt_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
    localparam int RW = $clog2(STALL_LIMIT) + 1;
    localparam logic [RW-1:0] RUN_MAX = RW'(STALL_LIMIT - 1);
    state_t state, state_nx;
    logic [RW-1:0] run_cnt;
    logic exc;
    assign exc = excepttype != 32'd0;
    // stall vector, flush/redirect and next state; everything held at 0 while in reset
    always_comb begin
        stall    = 6'b0;
        flush    = 1'b0;
        new_pc   = 32'd0;
        state_nx = RUN;
        if (rst) begin
            flush    = exc;
            new_pc   = !exc ? 32'd0 : (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
            stall    = exc            ? 6'b000000 :
                       stallreq_mem   ? 6'b011111 :
                       state == FLUSH ? 6'b000000 :
                       stallreq_ex    ? 6'b001111 :
                       stallreq_id    ? 6'b000111 : 6'b000000;
            state_nx = exc            ? FLUSH :
                       state == FLUSH ? RUN   :
                       stall != 6'b0  ? STALL : RUN;
        end
    end
    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nx;
    end
    // length of the current stall run, saturating at the watchdog threshold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                run_cnt <= '0;
        else if (stall == 6'b0)  run_cnt <= '0;
        else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
    end
    // sticky watchdog flag; never breaks the stall itself
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                       stall_timeout <= 1'b0;
        else if (stall_cnt_clr)                         stall_timeout <= 1'b0;
        else if (stall != 6'b0 && run_cnt == RUN_MAX)   stall_timeout <= 1'b1;
    end
    // saturating count of cycles with the PC held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   stall_cycles <= '0;
        else if (stall_cnt_clr)                     stall_cycles <= '0;
        else if (stall[0] && stall_cycles != '1)    stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench for pipe_stall_ctrl against a rule-level reference model
module tb_pipe_stall_ctrl;
    localparam int CW  = 4;
    localparam int LIM = 16;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic clk, rst, id, ex, mem, clr;
    logic [31:0] exct, epc;
    logic [5:0] stall;
    logic flush, to;
    logic [31:0] new_pc;
    logic [CW-1:0] cyc;

    typedef struct {
        logic [5:0]    st;
        logic          fl;
        logic [31:0]   pc;
        logic          to;
        logic [CW-1:0] cyc;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    bit m_fp;
    int m_run;
    bit m_to;
    int m_cyc;

    pipe_stall_ctrl #(.STALL_LIMIT(LIM), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(id), .stallreq_ex(ex), .stallreq_mem(mem),
        .excepttype(exct), .cp0_epc(epc), .stall_cnt_clr(clr),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_timeout(to), .stall_cycles(cyc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic drive(input bit r, input bit i, input bit e, input bit m,
                         input logic [31:0] x, input logic [31:0] p, input bit c);
        exp_t ev;
        int depth;
        @(posedge clk);
        #1;
        rst = r; id = i; ex = e; mem = m; exct = x; epc = p; clr = c;
        if (!r) begin
            ev.st = 6'b0; ev.fl = 1'b0; ev.pc = 32'd0; ev.to = 1'b0; ev.cyc = '0;
            m_fp = 0; m_run = 0; m_to = 0; m_cyc = 0;
        end else begin
            depth  = (x != 0) ? 0 : m ? 5 : m_fp ? 0 : e ? 4 : i ? 3 : 0;
            ev.st  = 6'((1 << depth) - 1);
            ev.fl  = (x != 0);
            ev.pc  = (x == 0) ? 32'd0 : (x == 32'h0000_000e) ? p : 32'h0000_0020;
            ev.to  = m_to;
            ev.cyc = CW'(m_cyc);
            if (depth != 0) begin
                if (m_run >= LIM - 1) m_to = 1;
                m_run++;
            end else m_run = 0;
            if (c) begin
                m_to = 0;
                m_cyc = 0;
            end else if (depth != 0 && m_cyc < (1 << CW) - 1) m_cyc++;
            m_fp = (x != 0);
        end
        q.push_back(ev);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(H, L, L, L, 32'd0, 32'd0, L);
    endtask

    initial begin : mon
        exp_t ev;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                ev = q.pop_front();
                chk("stall", 32'(stall), 32'(ev.st));
                chk("flush", 32'(flush), 32'(ev.fl));
                chk("new_pc", new_pc, ev.pc);
                chk("stall_timeout", 32'(to), 32'(ev.to));
                chk("stall_cycles", 32'(cyc), 32'(ev.cyc));
            end
        end
    end

    initial begin : stim
        bit r, i, e, m, c;
        logic [31:0] x;
        rst = 1'b0; id = 1'b0; ex = 1'b0; mem = 1'b0; clr = 1'b0;
        exct = 32'd0; epc = 32'd0;
        m_fp = 0; m_run = 0; m_to = 0; m_cyc = 0;
        drive(L, H, H, H, 32'd0, 32'd0, L);
        drive(L, H, H, H, 32'd0, 32'd0, L);
        drive(H, H, H, H, 32'd0, 32'd0, L);
        drive(H, H, H, L, 32'd0, 32'd0, L);
        drive(H, H, H, H, 32'd0, 32'd0, L);
        drive(H, L, L, L, 32'd0, 32'd0, L);
        drive(H, L, L, H, 32'd0, 32'd0, L);
        drive(H, L, L, H, 32'd1, 32'd0, L);
        drive(H, L, H, L, 32'd0, 32'd0, L);
        drive(H, L, H, L, 32'd0, 32'd0, L);
        idle(1);
        drive(H, L, L, L, 32'h0000_000e, 32'h0000_1234, L);
        idle(1);
        drive(H, L, L, L, 32'd5, 32'h0000_5678, L);
        drive(H, H, H, L, 32'h0000_000e, 32'h0000_9abc, L);
        drive(H, H, H, L, 32'd0, 32'd0, L);
        drive(H, H, L, H, 32'd3, 32'd0, L);
        drive(H, H, L, H, 32'd0, 32'd0, L);
        idle(1);
        drive(H, L, L, L, 32'd0, 32'd0, H);
        for (int k = 0; k < LIM - 1; k++) drive(H, L, H, L, 32'd0, 32'd0, L);
        idle(2);
        for (int k = 0; k < LIM; k++) drive(H, L, H, L, 32'd0, 32'd0, L);
        idle(3);
        drive(H, L, L, L, 32'd0, 32'd0, H);
        idle(1);
        for (int k = 0; k < 20; k++) drive(H, H, L, L, 32'd0, 32'd0, L);
        idle(2);
        drive(H, H, L, L, 32'd0, 32'd0, H);
        idle(1);
        for (int k = 0; k < 3; k++) drive(H, L, H, L, 32'd0, 32'd0, L);
        drive(L, L, H, L, 32'd0, 32'd0, L);
        drive(H, L, H, L, 32'd0, 32'd0, L);
        drive(H, L, L, H, 32'd1, 32'd0, L);
        drive(L, L, L, H, 32'd1, 32'd0, L);
        drive(H, L, H, L, 32'd0, 32'd0, L);
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(63) != 0);
            i = 1'($urandom_range(1));
            e = ($urandom_range(3) == 0);
            m = ($urandom_range(3) == 0);
            c = ($urandom_range(31) == 0);
            x = ($urandom_range(7) != 0) ? 32'd0 : ($urandom_range(1) != 0) ? 32'h0000_000e : $urandom;
            drive(r, i, e, m, x, $urandom, c);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
